// File: rtl/merge3_sched.sv
// merge3_sched: opcode-steered 3-to-1 four-phase handshake merge for writeback/commit.
// Optional MERGE3_PERF_EN adds per-channel completion counters and an error counter.
module merge3_sched #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       op_valid,
  input  logic       req_1,
  input  logic       req_2,
  input  logic       req_3,
  input  logic       ack_in,
  output logic       req_out,
  output logic       ack_out_1,
  output logic       ack_out_2,
  output logic       ack_out_3,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done,
  output logic       err_illegal,
  output logic       err_timeout
`ifdef MERGE3_PERF_EN
  ,
  output logic [15:0] cnt_1,
  output logic [15:0] cnt_2,
  output logic [15:0] cnt_3,
  output logic [7:0]  cnt_err
`endif
);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  typedef enum logic [2:0] {IDLE, WAIT_REQ, WAIT_ACK, WAIT_RLO, WAIT_ALO} state_t;
  logic [3:0] raw, syn;
  assign raw = {ack_in, req_3, req_2, req_1};
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign syn = raw;
    end else begin : g_sync
      logic [3:0] pipe_q [SYNC_STAGES];
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= raw;
          for (int i = 1; i < SYNC_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
        end
      assign syn = pipe_q[SYNC_STAGES-1];
    end
  endgenerate
  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d, sel_dec;
  logic [2:0] ack_q, ack_d, sel_oh;
  logic [TW-1:0] timer_q, timer_d;
  logic busy_q, busy_d, req_out_q, req_out_d, done_q, done_d;
  logic err_ill_q, err_ill_d, err_to_q, err_to_d, req_sel, ack_s;
  always_comb begin
    case (opcode)
      7'b1100011, 7'b1101111:                         sel_dec = 2'd1;
      7'b0100011:                                     sel_dec = 2'd2;
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0000000: sel_dec = 2'd3;
      default:                                        sel_dec = 2'd0;
    endcase
  end
  assign sel_oh  = {grant_q == 2'd3, grant_q == 2'd2, grant_q == 2'd1};
  assign req_sel = |(syn[2:0] & sel_oh);
  assign ack_s   = syn[3];
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = ack_q;
    timer_d   = timer_q;
    busy_d    = busy_q;
    req_out_d = req_out_q;
    done_d    = 1'b0;
    err_ill_d = 1'b0;
    err_to_d  = 1'b0;
    case (state_q)
      IDLE:
        if (op_valid && sel_dec != 2'd0) begin
          grant_d = sel_dec;
          busy_d  = 1'b1;
          timer_d = '0;
          state_d = WAIT_REQ;
        end else begin
          err_ill_d = op_valid;
        end
      WAIT_REQ:
        if (req_sel) begin
          req_out_d = 1'b1;
          state_d   = WAIT_ACK;
        end else begin
          timer_d = timer_q + 1'b1;
          if (TIMEOUT_CYC != 0 && timer_d == TW'(TIMEOUT_CYC)) begin
            err_to_d = 1'b1;
            grant_d  = 2'd0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      WAIT_ACK:
        if (ack_s) begin
          ack_d   = sel_oh;
          state_d = WAIT_RLO;
        end
      WAIT_RLO:
        if (!req_sel) begin
          req_out_d = 1'b0;
          state_d   = WAIT_ALO;
        end
      WAIT_ALO:
        if (!ack_s) begin
          ack_d   = 3'b000;
          done_d  = 1'b1;
          grant_d = 2'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      req_out_q <= 1'b0;
      done_q    <= 1'b0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      req_out_q <= req_out_d;
      done_q    <= done_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
    end
  assign req_out     = req_out_q;
  assign {ack_out_3, ack_out_2, ack_out_1} = ack_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;
`ifdef MERGE3_PERF_EN
  logic [15:0] cnt_q [3];
  logic [15:0] cnt_d [3];
  logic [7:0]  cnt_err_q, cnt_err_d;
  always_comb begin
    for (int i = 0; i < 3; i++) cnt_d[i] = cnt_q[i] + 16'(done_d && grant_q == 2'(i + 1));
    cnt_err_d = cnt_err_q + 8'((err_ill_d || err_to_d) && cnt_err_q != 8'hFF);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      cnt_err_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      cnt_err_q <= cnt_err_d;
    end
  assign cnt_1   = cnt_q[0];
  assign cnt_2   = cnt_q[1];
  assign cnt_3   = cnt_q[2];
  assign cnt_err = cnt_err_q;
`endif
endmodule

// File: tb/tb_merge3_sched.sv
// tb_merge3_sched: randomized transaction driver with an event scoreboard and latency checks.
module tb_merge3_sched;
  localparam int S = 2;
  localparam int T = 8;
  logic clk = 0, rst = 1, op_valid = 0, ack_in = 0;
  logic [6:0] opcode = 0;
  logic [2:0] reqv = 0;
  logic req_out, ack_out_1, ack_out_2, ack_out_3, busy, done, err_illegal, err_timeout;
  logic [1:0] grant;
  logic [2:0] acks;
`ifdef MERGE3_PERF_EN
  logic [15:0] cnt_1, cnt_2, cnt_3;
  logic [7:0] cnt_err;
`endif
  merge3_sched #(.SYNC_STAGES(S), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .op_valid(op_valid),
    .req_1(reqv[0]), .req_2(reqv[1]), .req_3(reqv[2]), .ack_in(ack_in),
    .req_out(req_out), .ack_out_1(ack_out_1), .ack_out_2(ack_out_2), .ack_out_3(ack_out_3),
    .grant(grant), .busy(busy), .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout)
`ifdef MERGE3_PERF_EN
    , .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3), .cnt_err(cnt_err)
`endif
  );
  assign acks = {ack_out_3, ack_out_2, ack_out_1};
  always #5 clk = ~clk;
  int n_cmp = 0, n_fail = 0, me = 0;
  int mc [4] = '{default: 0};
  logic [3:0] exp_q [$];
  logic [1:0] last_g = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  function automatic logic [1:0] dec(input logic [6:0] op);
    if (op inside {7'b1100011, 7'b1101111}) return 2'd1;
    if (op == 7'b0100011) return 2'd2;
    if (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0000000}) return 2'd3;
    return 2'd0;
  endfunction
  function automatic logic [2:0] oh(input logic [1:0] c);
    return {c == 2'd3, c == 2'd2, c == 2'd1};
  endfunction
  // Event scoreboard: kind 1 = done, 2 = illegal, 3 = timeout, paired with the channel.
  always @(negedge clk) begin
    logic [3:0] ev;
    if (rst) last_g = 0;
    else begin
      ev = done ? {2'd1, last_g} : err_illegal ? {2'd2, 2'd0} : err_timeout ? {2'd3, last_g} : 4'd0;
      if (ev != 0) begin
        if (exp_q.size() == 0) check("unexpected_event", 32'(ev), 0);
        else check("event", 32'(ev), 32'(exp_q.pop_front()));
      end
      if (|acks) check("ack_iso", 32'(acks & ~oh(grant)), 0);
      if (grant != 0) last_g = grant;
    end
  end
  task automatic noise(input logic [1:0] ch, input bit nz);
    if (nz) begin
      reqv = (3'($urandom) & ~oh(ch)) | (reqv & oh(ch));
      op_valid = 1'($urandom);
      opcode = 7'($urandom);
    end
  endtask
  function automatic logic obs(input int which, input logic [1:0] ch);
    return which == 0 ? req_out : which == 1 ? |(acks & oh(ch)) : done;
  endfunction
  task automatic wait_till(input int which, input logic [1:0] ch, input logic val, input bit nz, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      noise(ch, nz);
    end while (obs(which, ch) !== val && n < 40);
    op_valid = 0;
  endtask
  task automatic wait_lat(input string nm, input int which, input logic [1:0] ch, input logic val, input bit nz);
    int n;
    wait_till(which, ch, val, nz, n);
    check(nm, n, S + 1);
  endtask
  task automatic pause(input logic [1:0] ch, input bit nz);
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      noise(ch, nz);
    end
    op_valid = 0;
  endtask
  // k = cycles before the selected request rises (-1 = never); called on a falling edge.
  task automatic txn(input logic [6:0] op, input int k, input bit nz, input bit gap);
    logic [1:0] ch;
    bit to;
    int n;
    ch = dec(op);
    opcode = op;
    op_valid = 1;
    if (ch == 0) begin
      exp_q.push_back({2'd2, 2'd0});
      me++;
      @(negedge clk);
      op_valid = 0;
      opcode = 7'($urandom);
      check("ill_pulse", 32'(err_illegal), 1);
      check("ill_busy", 32'({busy, grant}), 0);
      @(negedge clk);
      check("ill_once", 32'(err_illegal), 0);
      return;
    end
    to = (k < 0) || (k > T - S);
    exp_q.push_back(to ? {2'd3, ch} : {2'd1, ch});
    if (k == 0) reqv |= oh(ch);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        op_valid = 0;
        opcode = 7'($urandom);
        check("grant", 32'(grant), 32'(ch));
        check("busy", 32'(busy), 1);
      end
      noise(ch, nz);
      if (n == k) reqv |= oh(ch);
    end while (!(to ? err_timeout : req_out) && n < T + S + 10);
    op_valid = 0;
    if (to) begin
      check("timeout_lat", n, T + 1);
      check("timeout_idle", 32'({busy, grant, req_out}), 0);
      me++;
    end else begin
      check("req_lat", n - k, S + 1);
      pause(ch, nz);
      ack_in = 1;
      wait_lat("ack_lat", 1, ch, 1, nz);
      pause(ch, nz);
      reqv &= ~oh(ch);
      wait_lat("rlo_lat", 0, ch, 0, nz);
      pause(ch, nz);
      ack_in = 0;
      wait_lat("done_lat", 2, ch, 1, nz);
      check("done_idle", 32'({busy, grant, acks}), 0);
      mc[ch]++;
    end
    if (gap) begin
      reqv = 0;
      repeat (S + 1) @(negedge clk);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [6:0] op;
    logic [6:0] legal [7];
    int k, n;
    bit nz;
    legal = '{7'b1100011, 7'b1101111, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0000011, 7'b0000000};
    #12;
    check("rst_outs", 32'({req_out, acks, grant, busy, done, err_illegal, err_timeout}), 0);
    @(negedge clk);
    rst = 0;
    txn(7'b0110011, 0, 0, 1);
    reqv = 3'b101;
    txn(7'b0100011, 4, 0, 1);
    txn(7'b0010111, 0, 0, 0);
    txn(7'b1101111, -1, 0, 1);
    txn(7'b1101111, T - S, 0, 1);
    txn(7'b1101111, T - S + 1, 0, 1);
    ack_in = 1;
    repeat (4) @(negedge clk);
    check("idle_ack", 32'({req_out, acks, busy}), 0);
    ack_in = 0;
    repeat (S + 1) @(negedge clk);
    opcode = 7'b1100011;
    op_valid = 1;
    reqv = 3'b001;
    wait_till(0, 1, 1, 0, n);
    ack_in = 1;
    wait_till(1, 1, 1, 0, n);
    check("rlo_state", 32'({req_out, acks}), 32'b1001);
    #2 rst = 1;
    #1 check("rst_async", 32'({req_out, acks, grant, busy, done}), 0);
    reqv = 0;
    ack_in = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    mc = '{default: 0};
    me = 0;
    txn(7'b1100011, 1, 0, 1);
    txn(7'b0110011, 0, 0, 0);
    txn(7'b0000011, 0, 0, 0);
    txn(7'b1100011, 0, 0, 0);
    txn(7'b0000000, 0, 0, 1);
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 7'($urandom); while (dec(op) != 0);
      end else op = legal[$urandom_range(0, 6)];
      k = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, T - S + 2));
      nz = 1'($urandom);
      txn(op, k, nz, (k < 0 || k > T - S || nz) ? 1'b1 : 1'($urandom));
    end
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
`ifdef MERGE3_PERF_EN
    check("cnt_1", 32'(cnt_1), mc[1] & 16'hFFFF);
    check("cnt_2", 32'(cnt_2), mc[2] & 16'hFFFF);
    check("cnt_3", 32'(cnt_3), mc[3] & 16'hFFFF);
    check("cnt_err", 32'(cnt_err), me > 255 ? 255 : me);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
